prog_loader: RTL and testbench

Boot-time program loader that sits directly upstream of the multicycle RISC-V core and its unified memory. It receives a framed byte stream (header, instruction words, checksum) over a valid/ready byte interface. It assembles little-endian 32-bit words and writes them into memory through a dedicated write port. The core is held in reset until a complete, checksum-verified image has been written, and then released.

---
 rtl/prog_loader.sv | 112 +++++++++++
 tb/tb_prog_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Boot loader: parses a counted byte frame, writes little-endian words to memory,
// and releases the core only after the XOR checksum of the data bytes matches.
module prog_loader #(
  parameter int          MEM_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        core_reset,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {HDR0, HDR1, DATA, CSUM, RUN, ERR} state_t;

  state_t      state, state_nxt;
  logic        xfer, last_byte;
  logic [7:0]  cnt_lo, csum;
  logic [15:0] n_hdr, n_words, word_idx;
  logic [1:0]  byte_cnt;
  logic [23:0] asm_q;
  logic        ready_d, run_d, err_d;

  assign xfer      = byte_valid && byte_ready;
  assign n_hdr     = {byte_data, cnt_lo};
  assign last_byte = (word_idx == n_words - 16'd1) && (byte_cnt == 2'd3);

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= HDR0;
    else       state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      HDR0: if (xfer) state_nxt = HDR1;
      HDR1: if (xfer) begin
        if ({16'd0, n_hdr} > 32'(MEM_WORDS)) state_nxt = ERR;
        else if (n_hdr == 16'd0)             state_nxt = CSUM;
        else                                 state_nxt = DATA;
      end
      DATA: if (xfer && last_byte) state_nxt = CSUM;
      CSUM: if (xfer) state_nxt = (byte_data == csum) ? RUN : ERR;
      default: ;
    endcase
  end

  // Status outputs are decoded from the next state so they change on the
  // same edge that moves the FSM.
  always_comb begin
    ready_d = (state_nxt == HDR0) || (state_nxt == HDR1) ||
              (state_nxt == DATA) || (state_nxt == CSUM);
    run_d   = (state_nxt == RUN);
    err_d   = (state_nxt == ERR);
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      byte_ready <= 1'b0;
      core_reset <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      byte_ready <= ready_d;
      core_reset <= !run_d;
      done       <= run_d;
      error      <= err_d;
    end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt_lo    <= '0;
      n_words   <= '0;
      word_idx  <= '0;
      byte_cnt  <= '0;
      asm_q     <= '0;
      csum      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      if (xfer) begin
        case (state)
          HDR0: cnt_lo  <= byte_data;
          HDR1: n_words <= n_hdr;
          DATA: begin
            csum     <= csum ^ byte_data;
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: asm_q[7:0]   <= byte_data;
              2'd1: asm_q[15:8]  <= byte_data;
              2'd2: asm_q[23:16] <= byte_data;
              default: begin
                mem_we    <= 1'b1;
                mem_addr  <= BASE_ADDR + {14'd0, word_idx, 2'b00};
                mem_wdata <= {byte_data, asm_q};
                word_idx  <= word_idx + 16'd1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: a cycle table for the nominal frame, plus directed and
// random frames checked each cycle against a positional frame-parsing model.
module tb_prog_loader;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             byte_valid = 1'b0;
  logic [7:0]       byte_data = 8'h00;
  logic [1:0]       rdy, we, crst, dn, er;
  logic [1:0][31:0] addr, wdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prog_loader dut0 (
    .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(rdy[0]), .mem_we(we[0]), .mem_addr(addr[0]), .mem_wdata(wdata[0]),
    .core_reset(crst[0]), .done(dn[0]), .error(er[0]));

  prog_loader #(.MEM_WORDS(4), .BASE_ADDR(32'h0000_0100)) dut1 (
    .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(rdy[1]), .mem_we(we[1]), .mem_addr(addr[1]), .mem_wdata(wdata[1]),
    .core_reset(crst[1]), .done(dn[1]), .error(er[1]));

  function automatic int mw_of(input int d);
    return (d == 0) ? 256 : 4;
  endfunction

  function automatic logic [31:0] base_of(input int d);
    return (d == 0) ? 32'h0 : 32'h100;
  endfunction

  // Outcome of having accepted exactly the bytes in q: st 0=loading 1=done 2=error,
  // nw = words written so far, la/ld = most recent write.
  function automatic void model(input logic [7:0] q[$], input int mw, input logic [31:0] base,
                                output int st, output int nw,
                                output logic [31:0] la, output logic [31:0] ld);
    int n;
    logic [7:0] x;
    st = 0; nw = 0; la = base; ld = 0; x = 0;
    if (q.size() < 2) return;
    n = int'({q[1], q[0]});
    if (n > mw) begin st = 2; return; end
    for (int k = 0; k < n; k++)
      if (2 + 4*k + 3 < q.size()) begin
        nw++;
        la = base + 32'(4*k);
        ld = {q[2+4*k+3], q[2+4*k+2], q[2+4*k+1], q[2+4*k]};
      end
    for (int i = 0; i < 4*n && 2 + i < q.size(); i++) x ^= q[2+i];
    if (q.size() > 2 + 4*n) st = (q[2+4*n] == x) ? 1 : 2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_dut(input int d, input int st, input logic we_e,
                            input logic [31:0] a_e, input logic [31:0] d_e);
    chk($sformatf("d%0d byte_ready", d), 32'(rdy[d]), 32'(st == 0));
    chk($sformatf("d%0d mem_we", d), 32'(we[d]), 32'(we_e));
    if (we_e) begin
      chk($sformatf("d%0d mem_addr", d), addr[d], a_e);
      chk($sformatf("d%0d mem_wdata", d), wdata[d], d_e);
    end
    chk($sformatf("d%0d core_reset", d), 32'(crst[d]), 32'(st != 1));
    chk($sformatf("d%0d done", d), 32'(dn[d]), 32'(st == 1));
    chk($sformatf("d%0d error", d), 32'(er[d]), 32'(st == 2));
  endtask

  task automatic expect_reset_vals();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d rst byte_ready", d), 32'(rdy[d]), 32'h0);
      chk($sformatf("d%0d rst mem_we", d), 32'(we[d]), 32'h0);
      chk($sformatf("d%0d rst mem_addr", d), addr[d], base_of(d));
      chk($sformatf("d%0d rst mem_wdata", d), wdata[d], 32'h0);
      chk($sformatf("d%0d rst core_reset", d), 32'(crst[d]), 32'h1);
      chk($sformatf("d%0d rst done", d), 32'(dn[d]), 32'h0);
      chk($sformatf("d%0d rst error", d), 32'(er[d]), 32'h0);
    end
  endtask

  // Called just after a posedge; reset takes effect without waiting for a clock.
  task automatic do_reset();
    byte_valid = 1'b0;
    reset = 1'b1;
    #1 expect_reset_vals();
    @(posedge clk); #1 expect_reset_vals();
    reset = 1'b0;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) expect_dut(d, 0, 1'b0, 0, 0);
  endtask

  task automatic upd(input int d, input logic [7:0] b, input logic [7:0] qi[$],
                     output logic [7:0] qo[$]);
    int st0, nw0, st1, nw1;
    logic [31:0] la, ld;
    model(qi, mw_of(d), base_of(d), st0, nw0, la, ld);
    qo = qi;
    if (st0 == 0) qo.push_back(b);
    model(qo, mw_of(d), base_of(d), st1, nw1, la, ld);
    expect_dut(d, st1, nw1 > nw0, la, ld);
  endtask

  task automatic gap_chk(input int d, input logic [7:0] q[$]);
    int st, nw;
    logic [31:0] la, ld;
    model(q, mw_of(d), base_of(d), st, nw, la, ld);
    expect_dut(d, st, 1'b0, 0, 0);
  endtask

  task automatic run_frame(input logic [7:0] q[$], input int gap_pct);
    logic [7:0] acc0[$], acc1[$];
    acc0 = {}; acc1 = {};
    foreach (q[i]) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
        @(posedge clk); #1;
        gap_chk(0, acc0);
        gap_chk(1, acc1);
      end
      byte_valid = 1'b1;
      byte_data  = q[i];
      @(posedge clk); #1;
      byte_valid = 1'b0;
      upd(0, q[i], acc0, acc0);
      upd(1, q[i], acc1, acc1);
    end
  endtask

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        rdy, we;
    logic [31:0] a, wd;
    logic        cr, dn, er;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] nom[$], q[$];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog timeout actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    nom = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h33, 8'h81, 8'h10, 8'h00, 8'h61};
    vecs = '{
      '{1'b1, 8'h02, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0},
      '{1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0},
      '{1'b1, 8'h93, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0},
      '{1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0},
      '{1'b1, 8'h50, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0},
      '{1'b1, 8'h00, 1'b1, 1'b1, 32'h0, 32'h00500093, 1'b1, 1'b0, 1'b0},
      '{1'b1, 8'h33, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0},
      '{1'b0, 8'hee, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0},
      '{1'b1, 8'h81, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0},
      '{1'b1, 8'h10, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0},
      '{1'b1, 8'h00, 1'b1, 1'b1, 32'h4, 32'h00108133, 1'b1, 1'b0, 1'b0},
      '{1'b1, 8'h61, 1'b0, 1'b0, 32'h0, 32'h0,        1'b0, 1'b1, 1'b0},
      '{1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0,        1'b0, 1'b1, 1'b0},
      '{1'b1, 8'h55, 1'b0, 1'b0, 32'h0, 32'h0,        1'b0, 1'b1, 1'b0}
    };

    @(posedge clk); #1;
    do_reset();

    // cycle table, nominal frame on the default instance
    for (int i = 0; i < vecs.size(); i++) begin
      byte_valid = vecs[i].v;
      byte_data  = vecs[i].d;
      @(posedge clk); #1;
      byte_valid = 1'b0;
      chk($sformatf("tbl%0d byte_ready", i), 32'(rdy[0]), 32'(vecs[i].rdy));
      chk($sformatf("tbl%0d mem_we", i), 32'(we[0]), 32'(vecs[i].we));
      if (vecs[i].we) begin
        chk($sformatf("tbl%0d mem_addr", i), addr[0], vecs[i].a);
        chk($sformatf("tbl%0d mem_wdata", i), wdata[0], vecs[i].wd);
      end
      chk($sformatf("tbl%0d core_reset", i), 32'(crst[0]), 32'(vecs[i].cr));
      chk($sformatf("tbl%0d done", i), 32'(dn[0]), 32'(vecs[i].dn));
      chk($sformatf("tbl%0d error", i), 32'(er[0]), 32'(vecs[i].er));
    end

    do_reset(); run_frame(nom, 0);

    q = nom; q[10] = 8'h62;
    q.push_back(8'h04); q.push_back(8'h00); q.push_back(8'h11);
    q.push_back(8'h22); q.push_back(8'h33); q.push_back(8'h44);
    do_reset(); run_frame(q, 0);

    // oversize for the 4-word instance
    q = '{8'h05, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    do_reset(); run_frame(q, 0);

    q = '{8'h00, 8'h00, 8'h00};
    do_reset(); run_frame(q, 0);

    do_reset(); run_frame(nom, 50);

    // abort with a write in flight, then after 5 data bytes; both reload cleanly
    for (int k = 6; k <= 7; k++) begin
      q = nom[0:k-1];
      do_reset(); run_frame(q, 0);
      do_reset(); run_frame(nom, 0);
    end

    for (int t = 0; t < 20; t++) begin
      int n;
      logic [7:0] x, b;
      n = $urandom_range(0, 6);
      q = '{8'(n), 8'h00};
      x = 8'h00;
      for (int i = 0; i < 4*n; i++) begin
        b = 8'($urandom);
        x ^= b;
        q.push_back(b);
      end
      q.push_back(($urandom_range(0, 3) == 0) ? (x ^ 8'h01) : x);
      for (int i = 0; i < int'($urandom_range(0, 2)); i++) q.push_back(8'($urandom));
      do_reset();
      run_frame(q, $urandom_range(0, 60));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
